cmem_alloc_ctrl: RTL
====================

// Module: cmem_alloc_ctrl
// PURPOSE
//  Owns the 1024x16 control memory (cmem) that mirrors the 32-byte data-memory segments.
//  Serves two requesters:
//   - alloc: build a linked chain of N free blocks; return the head address.
//   - free:  walk a chain from its head and release every block.
//  Sits between the ingress writer / egress reader and cmem; keeps a free-block count.
// PARAMETERS
//  ADDR_W  10    cmem address width; address 0 is the reserved null / end-of-chain marker
//  DEPTH   1024  cmem entries (2**ADDR_W)
//  DATA_W  16    entry width: [15]=is_allocated, [9:0]=next_addr, [14:10]=0
//  LEN_W   6     alloc length width, in blocks
// PORTS
//  clk         in   1       single clock
//  rst_n       in   1       asynchronous, active-low reset
//  alloc_req   in   1       alloc request; held high until alloc_ack
//  alloc_len   in   LEN_W   blocks requested; stable while alloc_req is high
//  alloc_ack   out  1       1-cycle pulse: alloc finished
//  alloc_ok    out  1       valid with alloc_ack; 1 = chain built
//  alloc_head  out  ADDR_W  valid with alloc_ack and alloc_ok; first block of the chain
//  free_req    in   1       free request; held high until free_ack
//  free_head   in   ADDR_W  head of the chain to release; stable while free_req is high
//  free_ack    out  1       1-cycle pulse: free finished
//  free_err    out  1       valid with free_ack; 1 = head==0, or an unallocated entry hit mid-walk
//  free_cnt    out  ADDR_W+1  number of unallocated blocks (max DEPTH-1)
//  busy        out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=INIT; scan_ptr=1; free_cnt=0; rr_last=FREE.
//  Memory: read data (port A) returns 1 cycle after the address; port B is write-only.
//  INIT: one write per cycle, cmem[k]<=0 for k=0..DEPTH-1 (DEPTH cycles).
//   - After INIT: free_cnt=DEPTH-1, go to IDLE.
//   - Requests are ignored until IDLE.
//  IDLE arbitration:
//   - Only one requester high: serve it.
//   - Both high: serve the one not served last (rr_last), then update rr_last.
//   - alloc_len/free_head are captured when the request is accepted.
//  ALLOC:
//   - alloc_len==0 or alloc_len>free_cnt: alloc_ack with ok=0 on the next cycle; cmem untouched.
//   - Otherwise, next-fit scan from scan_ptr with states A_RD (issue read) and A_CHK
//     (examine data): 2 cycles per entry.
//   - Scan wraps DEPTH-1 -> 1; address 0 is never scanned.
//   - Free entry found in A_CHK:
//     - First found: latch it as head.
//     - Otherwise: write prev <= {1,cur} on port B.
//     - In all cases: prev=cur, remaining--.
//   - remaining reaches 0: write prev <= 16'h8000, free_cnt -= len,
//     scan_ptr = cur+1 (wrapping), then ALLOC_ACK (ok=1, head).
//   - Termination is guaranteed: len<=free_cnt, so fewer than DEPTH entries are scanned
//     and no entry is revisited.
//  FREE:
//   - head==0: free_ack with err=1 on the next cycle.
//   - Otherwise walk F_RD/F_CHK (2 cycles per block):
//     - Entry [15]==0: free_ack with err=1; stop; blocks already freed stay freed.
//     - Else write cur <= 0, free_cnt++.
//     - next==0: free_ack with err=0; else cur=next.
//  ACK states: last 1 cycle, then return to IDLE.
//   - Requester drops req on the ack cycle; a req still high 1 cycle after ack is a new request.
//  Reset mid-operation: state is lost and the FSM re-enters INIT, so cmem is fully cleared
//  (partial chains are discarded).
//  Width rules:
//   - free_cnt is ADDR_W+1 bits and never under/overflows in legal use.
//   - scan_ptr wrap is computed in ADDR_W bits and skips 0.
// STRUCTURE
//  Package cmem_pkg:
//   - ADDR_W/DATA_W/LEN_W constants.
//   - cmem_entry_t packed struct {alloc, rsvd[4:0], next[9:0]}.
//   - NULL_ADDR = 0.
//   - state enum {INIT, IDLE, A_RD, A_CHK, A_ACK, F_RD, F_CHK, F_ACK}.
//  One sub-module: true_dual_port_mem (MEM_SIZE=DEPTH, DATA_WIDTH=DATA_W).
//   - Port A: read.
//   - Port B: write.
// TESTING
//  1. Reset, wait: busy stays high 1024 cycles; then free_cnt=1023, all cmem reads 0.
//  2. alloc_len=2 after init -> ok=1, head=1; cmem[1]=16'h8002, cmem[2]=16'h8000; free_cnt=1021.
//  3. Then free_head=1 -> free_ack, err=0; cmem[1]=cmem[2]=0; free_cnt=1023; next alloc_len=1 -> head=3.
//  4. alloc_len=0 -> ok=0.
//     Fill with allocs until free_cnt=5, then alloc_len=6 -> ok=0; cmem unchanged.
//  5. alloc_req and free_req rise in the same cycle (rr_last=FREE) -> alloc served first, then free.
//  6. Free of unallocated head=500 -> err=1. Also: rst_n pulse mid-alloc -> INIT rerun; free_cnt=1023.

Source files
------------

// File: rtl/cmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmem_pkg : shared constants, entry layout and FSM states for cmem control |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cmem_pkg;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 6;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

    typedef struct packed {
        logic              alloc;
        logic [4:0]        rsvd;
        logic [ADDR_W-1:0] next;
    } cmem_entry_t;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        A_RD  = 3'd2,
        A_CHK = 3'd3,
        A_ACK = 3'd4,
        F_RD  = 3'd5,
        F_CHK = 3'd6,
        F_ACK = 3'd7
    } state_t;

    typedef enum logic {
        RR_ALLOC = 1'b0,
        RR_FREE  = 1'b1
    } rr_t;

    // Address 0 is the null marker, so the scan wraps from the top entry back to 1.
    function automatic logic [ADDR_W-1:0] next_scan(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? ADDR_W'(1) : a + ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmem_alloc_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmem_alloc_ctrl_if : alloc/free request bus of the cmem allocator         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface cmem_alloc_ctrl_if;
    import cmem_pkg::*;

    logic              alloc_req;
    logic [LEN_W-1:0]  alloc_len;
    logic              alloc_ack;
    logic              alloc_ok;
    logic [ADDR_W-1:0] alloc_head;
    logic              free_req;
    logic [ADDR_W-1:0] free_head;
    logic              free_ack;
    logic              free_err;
    logic [CNT_W-1:0]  free_cnt;
    logic              busy;

    modport master (
        output alloc_req, alloc_len, free_req, free_head,
        input  alloc_ack, alloc_ok, alloc_head, free_ack, free_err, free_cnt, busy
    );

    modport slave (
        input  alloc_req, alloc_len, free_req, free_head,
        output alloc_ack, alloc_ok, alloc_head, free_ack, free_err, free_cnt, busy
    );

endinterface
`default_nettype wire

// File: rtl/true_dual_port_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | true_dual_port_mem : port A registered read, port B write                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module true_dual_port_mem #(
    parameter int MEM_SIZE   = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  wire logic                  clk,
    input  wire logic [ADDR_WIDTH-1:0] a_addr,
    output logic      [DATA_WIDTH-1:0] a_rdata,
    input  wire logic                  b_we,
    input  wire logic [ADDR_WIDTH-1:0] b_addr,
    input  wire logic [DATA_WIDTH-1:0] b_wdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        a_rdata <= r_mem[a_addr];
        if (b_we) begin
            r_mem[b_addr] <= b_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmem_alloc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmem_alloc_ctrl : builds and releases linked block chains in cmem         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cmem_alloc_ctrl (
    input  wire logic         clk,
    input  wire logic         rst_n,
    cmem_alloc_ctrl_if.slave  bus
);
    import cmem_pkg::*;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_init_ptr;
    logic [ADDR_W-1:0] r_scan_ptr;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_prev;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_len;
    logic              r_first;
    logic [CNT_W-1:0]  r_free_cnt;
    rr_t               r_rr_last;
    logic              r_alloc_ok;
    logic [ADDR_W-1:0] r_alloc_head;
    logic              r_free_err;

    logic [DATA_W-1:0] w_rd_data;
    cmem_entry_t       w_rd_entry;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    cmem_entry_t       w_wr_data;
    logic              w_pick_alloc;
    logic              w_pick_free;
    logic              w_alloc_bad;
    logic              w_hit;
    logic              w_last;
    logic              w_unused_rsvd;

    assign w_rd_entry    = cmem_entry_t'(w_rd_data);
    assign w_unused_rsvd = ^w_rd_entry.rsvd;
    assign w_hit         = ~w_rd_entry.alloc;
    assign w_last        = (r_remaining == LEN_W'(1));
    assign w_alloc_bad   = (bus.alloc_len == '0) || (CNT_W'(bus.alloc_len) > r_free_cnt);

    true_dual_port_mem #(
        .MEM_SIZE   (DEPTH),
        .DATA_WIDTH (DATA_W)
    ) u_mem (
        .clk     (clk),
        .a_addr  (r_cur),
        .a_rdata (w_rd_data),
        .b_we    (w_wr_en),
        .b_addr  (w_wr_addr),
        .b_wdata (w_wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_prev;
        w_wr_data    = '0;
        w_pick_alloc = 1'b0;
        w_pick_free  = 1'b0;
        case (r_state)
            INIT: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_init_ptr;
                if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                if (bus.alloc_req && (!bus.free_req || r_rr_last == RR_FREE)) begin
                    w_pick_alloc = 1'b1;
                    w_next_state = w_alloc_bad ? A_ACK : A_RD;
                end else if (bus.free_req) begin
                    w_pick_free  = 1'b1;
                    w_next_state = (bus.free_head == NULL_ADDR) ? F_ACK : F_RD;
                end
            end
            A_RD: w_next_state = A_CHK;
            A_CHK: begin
                if (w_hit && !r_first) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_prev;
                    w_wr_data = '{alloc: 1'b1, rsvd: '0, next: r_cur};
                end
                w_next_state = (w_hit && w_last) ? A_ACK : A_RD;
            end
            A_ACK: begin
                // Terminal link is deferred here because A_CHK already uses the write port.
                if (r_alloc_ok) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_prev;
                    w_wr_data = '{alloc: 1'b1, rsvd: '0, next: NULL_ADDR};
                end
                w_next_state = IDLE;
            end
            F_RD: w_next_state = F_CHK;
            F_CHK: begin
                if (!w_rd_entry.alloc) begin
                    w_next_state = F_ACK;
                end else begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = r_cur;
                    w_next_state = (w_rd_entry.next == NULL_ADDR) ? F_ACK : F_RD;
                end
            end
            F_ACK:   w_next_state = IDLE;
            default: w_next_state = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_ptr   <= '0;
            r_scan_ptr   <= ADDR_W'(1);
            r_cur        <= '0;
            r_prev       <= '0;
            r_remaining  <= '0;
            r_len        <= '0;
            r_first      <= 1'b0;
            r_free_cnt   <= '0;
            r_rr_last    <= RR_FREE;
            r_alloc_ok   <= 1'b0;
            r_alloc_head <= '0;
            r_free_err   <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_ptr <= r_init_ptr + ADDR_W'(1);
                    if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_free_cnt <= CNT_W'(DEPTH - 1);
                    end
                end
                IDLE: begin
                    if (w_pick_alloc) begin
                        r_rr_last   <= RR_ALLOC;
                        r_len       <= bus.alloc_len;
                        r_remaining <= bus.alloc_len;
                        r_cur       <= r_scan_ptr;
                        r_first     <= 1'b1;
                        r_alloc_ok  <= ~w_alloc_bad;
                    end else if (w_pick_free) begin
                        r_rr_last  <= RR_FREE;
                        r_cur      <= bus.free_head;
                        r_free_err <= (bus.free_head == NULL_ADDR);
                    end
                end
                A_CHK: begin
                    r_cur <= next_scan(r_cur);
                    if (w_hit) begin
                        r_first     <= 1'b0;
                        r_prev      <= r_cur;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_first) begin
                            r_alloc_head <= r_cur;
                        end
                        if (w_last) begin
                            r_free_cnt <= r_free_cnt - CNT_W'(r_len);
                            r_scan_ptr <= next_scan(r_cur);
                        end
                    end
                end
                F_CHK: begin
                    if (!w_rd_entry.alloc) begin
                        r_free_err <= 1'b1;
                    end else begin
                        r_free_err <= 1'b0;
                        r_free_cnt <= r_free_cnt + CNT_W'(1);
                        r_cur      <= w_rd_entry.next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alloc_ack  = (r_state == A_ACK);
    assign bus.alloc_ok   = r_alloc_ok;
    assign bus.alloc_head = r_alloc_head;
    assign bus.free_ack   = (r_state == F_ACK);
    assign bus.free_err   = r_free_err;
    assign bus.free_cnt   = r_free_cnt;
    assign bus.busy       = rst_n && (r_state != IDLE);

endmodule
`default_nettype wire
